// File: rtl/step_controller.sv
// step_controller: debounced step/run/reset front-end that gates the datapath clock-enable; STEP_BREAKPOINT_EN adds PC breakpoint halting
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 25000000,
    parameter int RST_CYCLES      = 4,
    parameter int PC_W            = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_step_n,
    input  logic            btn_mode_n,
    input  logic            btn_cpurst_n,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bp_addr,
    output logic            cpu_ce,
    output logic            cpu_reset,
    output logic            running,
    output logic            halted
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RUN_DIV);
    localparam int TW = $clog2(RST_CYCLES + 1);
    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [2:0] raw, press;
    assign raw = {btn_cpurst_n, btn_mode_n, btn_step_n};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic          sync1, sync2, level, pulse, done;
        logic [DW-1:0] cnt;
        assign done = (sync2 != level) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                level <= 1'b1;
                pulse <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= raw[g];
                sync2 <= sync1;
                cnt   <= (sync2 == level || done) ? '0 : cnt + 1'b1;
                level <= done ? sync2 : level;
                pulse <= done & ~sync2;
            end
        end
        assign press[g] = pulse;
    end

    logic rst_p, mode_p, step_p;
    assign rst_p  = press[2];
    assign mode_p = press[1] & ~press[2];
    assign step_p = press[0] & ~|press[2:1];

    logic [1:0]    state;
    logic [RW-1:0] run_cnt;
    logic [TW-1:0] rst_cnt;
    logic          bp_armed, wrap, bp_hit;
    assign wrap = run_cnt == RW'(RUN_DIV - 1);

`ifdef STEP_BREAKPOINT_EN
    assign bp_hit = (state == S_RUN) && bp_armed && (pc == bp_addr) && wrap && !rst_p && !mode_p;
    assign halted = state == S_HALT;
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_armed};
    assign bp_hit    = 1'b0;
    assign halted    = 1'b0;
`endif

    assign cpu_reset = state == S_RESET;
    assign running   = state == S_RUN;
    assign cpu_ce    = ((state == S_STEP || state == S_HALT) && step_p) ||
                       ((state == S_RUN) && wrap && !rst_p && !mode_p && !bp_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            rst_cnt  <= '0;
            run_cnt  <= '0;
            bp_armed <= 1'b0;
        end else if (rst_p) begin
            state   <= S_RESET;
            rst_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_cnt == TW'(RST_CYCLES - 1)) state <= S_STEP;
                    else rst_cnt <= rst_cnt + 1'b1;
                end
                S_STEP: begin
                    if (mode_p) begin
                        state    <= S_RUN;
                        run_cnt  <= '0;
                        bp_armed <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (mode_p) state <= S_STEP;
                    else begin
                        run_cnt <= wrap ? '0 : run_cnt + 1'b1;
                        if (bp_hit) state <= S_HALT;
                        if (cpu_ce) bp_armed <= 1'b1;
                    end
                end
                default: begin
                    // Resuming from a halt skips the breakpoint once so its instruction runs
                    if (mode_p) begin
                        state    <= S_RUN;
                        run_cnt  <= '0;
                        bp_armed <= 1'b0;
                    end else if (step_p) state <= S_STEP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed vector bench for step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=5, RST_CYCLES=3)
module tb_step_controller;
    logic       clk = 0, reset = 1;
    logic       btn_step_n = 1, btn_mode_n = 1, btn_cpurst_n = 1;
    logic [7:0] pc = 0, bp_addr = 8'hFF;
    logic       cpu_ce, cpu_reset, running, halted;
    int         checks = 0, errors = 0;
    int         ce_n, rst_n;

    typedef struct {
        string      name;
        logic [2:0] btns;
        int         hold, total, ce, rst;
        logic       run, halt;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5), .RST_CYCLES(3), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .btn_step_n(btn_step_n), .btn_mode_n(btn_mode_n),
        .btn_cpurst_n(btn_cpurst_n), .pc(pc), .bp_addr(bp_addr), .cpu_ce(cpu_ce),
        .cpu_reset(cpu_reset), .running(running), .halted(halted)
    );

    // Datapath model: PC advances by 4 on each enabled edge
    always @(posedge clk) pc <= cpu_reset ? 8'd0 : cpu_ce ? pc + 8'd4 : pc;

    always @(negedge clk) begin
        checks++;
        if (cpu_ce && cpu_reset) begin
            errors++;
            $display("FAIL overlap cpu_ce=%b cpu_reset=%b required never both high", cpu_ce, cpu_reset);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic [2:0] btns, input int hold, input int total);
        ce_n = 0;
        rst_n = 0;
        {btn_cpurst_n, btn_mode_n, btn_step_n} = btns;
        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            ce_n += int'(cpu_ce);
            rst_n += int'(cpu_reset);
            if (k == hold) {btn_cpurst_n, btn_mode_n, btn_step_n} = 3'b111;
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{"step_glitch",     3'b110, 3, 12, 0, 0, 1'b0, 1'b0};
        vecs[1] = '{"step_press",      3'b110, 10, 20, 1, 0, 1'b0, 1'b0};
        vecs[2] = '{"mode_to_run",     3'b101, 8, 30, 4, 0, 1'b1, 1'b0};
        vecs[3] = '{"step_in_run",     3'b110, 6, 25, 5, 0, 1'b1, 1'b0};
        vecs[4] = '{"cpurst_in_run",   3'b011, 6, 12, 1, 3, 1'b0, 1'b0};
        vecs[5] = '{"mode_step_same",  3'b100, 8, 14, 1, 0, 1'b1, 1'b0};
        vecs[6] = '{"mode_to_step",    3'b101, 8, 14, 1, 0, 1'b0, 1'b0};
        vecs[7] = '{"step_again",      3'b110, 8, 14, 1, 0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_reset", int'(cpu_reset), 1);
        check("reset_cpu_ce", int'(cpu_ce), 0);
        check("reset_running", int'(running), 0);
        check("reset_halted", int'(halted), 0);
        reset = 0;
        ce_n = 0;
        rst_n = 0;
        for (int k = 0; k < 10; k++) begin
            ce_n += int'(cpu_ce);
            rst_n += int'(cpu_reset);
            @(posedge clk); #1;
        end
        check("release_rst_cycles", rst_n, 3);
        check("release_ce", ce_n, 0);
        check("release_running", int'(running), 0);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].btns, vecs[i].hold, vecs[i].total);
            check({vecs[i].name, "_ce"}, ce_n, vecs[i].ce);
            check({vecs[i].name, "_rst"}, rst_n, vecs[i].rst);
            check({vecs[i].name, "_running"}, int'(running), int'(vecs[i].run));
            check({vecs[i].name, "_halted"}, int'(halted), int'(vecs[i].halt));
        end

        apply(3'b101, 8, 10);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (cpu_ce) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("midrun_ce_seen", int'(found), 1);
        reset = 1;
        @(posedge clk); #1;
        check("midrun_reset_ce", int'(cpu_ce), 0);
        check("midrun_reset_cpu_reset", int'(cpu_reset), 1);
        check("midrun_reset_running", int'(running), 0);
        reset = 0;
        repeat (5) @(posedge clk);
        #1;
        check("after_reset_cpu_reset", int'(cpu_reset), 0);

        bp_addr = 8'h08;
        apply(3'b101, 8, 30);
`ifdef STEP_BREAKPOINT_EN
        check("bp_ce", ce_n, 2);
        check("bp_halted", int'(halted), 1);
        check("bp_running", int'(running), 0);
        check("bp_pc", int'(pc), 8);
        apply(3'b101, 8, 30);
        check("resume_ce", ce_n, 4);
        check("resume_halted", int'(halted), 0);
        check("resume_running", int'(running), 1);
        check("resume_pc", int'(pc), 24);
`else
        check("nobp_ce", ce_n, 4);
        check("nobp_halted", int'(halted), 0);
        check("nobp_running", int'(running), 1);
        check("nobp_pc", int'(pc), 16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
